// File: rtl/vm_coin_sequencer.sv
// Customer-side coin driver for the vending core: turns accepted coin requests into
// fixed-width one-hot coin pulses, tracks credit and reports the core's vend outcome.
module vm_coin_sequencer #(
    parameter int PULSE_CYCLES = 4,
    parameter int GAP_CYCLES   = 2,
    parameter int PRICE        = 15,
    parameter int TIMEOUT      = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [1:0] req_coin,
    output logic       coin_5,
    output logic       coin_10,
    input  logic       vm_dispense,
    input  logic       vm_change,
    output logic [4:0] credit,
    output logic       busy,
    output logic       done_valid,
    output logic       done_change,
    output logic       err_change,
    output logic       err_timeout,
    output logic       err_spurious,
    output logic       err_illegal
);

    localparam int CNT_MAX_A = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
    localparam int CNT_MAX   = (CNT_MAX_A > TIMEOUT) ? CNT_MAX_A : TIMEOUT;
    localparam int CNT_W     = $clog2(CNT_MAX + 1);

    typedef enum logic [1:0] {IDLE, DRIVE, GAP, WAIT_VEND} state_t;

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [4:0]       credit_n;
    logic             coin_sel_10, coin_sel_10_n;
    logic             coin_5_n, coin_10_n;
    logic             done_valid_n, done_change_n, err_change_n;
    logic             err_timeout_n, err_spurious_n, err_illegal_n;
    logic             legal_coin;

    assign legal_coin = (req_coin == 2'b01) || (req_coin == 2'b10);

    // Both ready and busy depend only on the state register, so they stay glitch-free.
    assign req_ready = (state == IDLE);
    assign busy      = (state != IDLE);

    always_comb begin
        state_n        = state;
        cnt_n          = cnt;
        credit_n       = credit;
        coin_sel_10_n  = coin_sel_10;
        coin_5_n       = 1'b0;
        coin_10_n      = 1'b0;
        done_valid_n   = 1'b0;
        done_change_n  = 1'b0;
        err_change_n   = 1'b0;
        err_timeout_n  = 1'b0;
        err_illegal_n  = 1'b0;
        err_spurious_n = vm_dispense && (state != WAIT_VEND);

        case (state)
            IDLE: begin
                if (req_valid) begin
                    if (legal_coin) begin
                        coin_sel_10_n = req_coin[1];
                        credit_n      = credit + (req_coin[1] ? 5'd10 : 5'd5);
                        coin_5_n      = !req_coin[1];
                        coin_10_n     = req_coin[1];
                        cnt_n         = '0;
                        state_n       = DRIVE;
                    end else begin
                        err_illegal_n = 1'b1;
                    end
                end
            end
            DRIVE: begin
                // The line was raised on the handshake edge, so this state holds it for the rest.
                if (cnt == CNT_W'(PULSE_CYCLES - 1)) begin
                    cnt_n   = '0;
                    state_n = GAP;
                end else begin
                    coin_5_n  = !coin_sel_10;
                    coin_10_n = coin_sel_10;
                    cnt_n     = cnt + 1'b1;
                end
            end
            GAP: begin
                if (cnt == CNT_W'(GAP_CYCLES - 1)) begin
                    cnt_n   = '0;
                    state_n = (credit >= 5'(PRICE)) ? WAIT_VEND : IDLE;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            WAIT_VEND: begin
                // A dispense on the last counted cycle wins over the timeout.
                if (vm_dispense) begin
                    done_valid_n  = 1'b1;
                    done_change_n = vm_change;
                    err_change_n  = (vm_change != (credit > 5'(PRICE)));
                    credit_n      = '0;
                    cnt_n         = '0;
                    state_n       = IDLE;
                end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                    err_timeout_n = 1'b1;
                    credit_n      = '0;
                    cnt_n         = '0;
                    state_n       = IDLE;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            credit       <= '0;
            coin_sel_10  <= 1'b0;
            coin_5       <= 1'b0;
            coin_10      <= 1'b0;
            done_valid   <= 1'b0;
            done_change  <= 1'b0;
            err_change   <= 1'b0;
            err_timeout  <= 1'b0;
            err_spurious <= 1'b0;
            err_illegal  <= 1'b0;
        end else begin
            state        <= state_n;
            cnt          <= cnt_n;
            credit       <= credit_n;
            coin_sel_10  <= coin_sel_10_n;
            coin_5       <= coin_5_n;
            coin_10      <= coin_10_n;
            done_valid   <= done_valid_n;
            done_change  <= done_change_n;
            err_change   <= err_change_n;
            err_timeout  <= err_timeout_n;
            err_spurious <= err_spurious_n;
            err_illegal  <= err_illegal_n;
        end
    end

endmodule

// File: doc/vm_coin_sequencer.md
Name: vm_coin_sequencer

Overview:
- Customer-side initiator for the vending machine core. It drives the core's coin-input lines, which is the opposite end of the interface the top-level harness exercises.
- Accepts coin requests over a valid/ready handshake and turns each coin into a fixed-width one-hot pulse on the core's coin lines.
- Tracks the running credit, then waits for the core's dispense/change response and reports the outcome.
- Used on-chip as a self-test driver and in benches as the synthesizable stimulus source.

Parameters:
- PULSE_CYCLES, 4, cycles a coin line is held high per coin (>=1)
- GAP_CYCLES, 2, cycles both coin lines are held low after each pulse (>=1)
- PRICE, 15, product price in cents; must be a multiple of 5, 5..25
- TIMEOUT, 16, maximum cycles spent in WAIT_VEND before err_timeout (>=2)

Ports:
- clk  input  1  single clock; all logic is on the rising edge
- rst  input  1  synchronous, active-high reset
- req_valid  input  1  coin request present
- req_ready  output  1  sequencer can accept a request
- req_coin  input  2  coin code: 01 = 5c, 10 = 10c; 00 and 11 are illegal
- coin_5  output  1  to core: 5c coin pulse
- coin_10  output  1  to core: 10c coin pulse
- vm_dispense  input  1  from core: product dispensed
- vm_change  input  1  from core: change returned (valid together with vm_dispense)
- credit  output  5  current accumulated credit in cents
- busy  output  1  high whenever the state is not IDLE
- done_valid  output  1  one-cycle pulse: vend completed
- done_change  output  1  vm_change captured at the dispense; valid only with done_valid
- err_change  output  1  one-cycle pulse with done_valid when vm_change != (credit > PRICE)
- err_timeout  output  1  one-cycle pulse: no dispense within TIMEOUT
- err_spurious  output  1  one-cycle pulse: vm_dispense high outside WAIT_VEND
- err_illegal  output  1  one-cycle pulse: illegal req_coin consumed

Behaviour:
- Reset: state IDLE, credit = 0, all counters = 0, and every output low except req_ready = 1. Coin lines go low on the cycle after rst is sampled high, including when rst arrives mid-pulse.
- Outputs are registered. A handshake completes when req_valid and req_ready are both high on a rising edge.
- req_ready = 1 only in IDLE.
- IDLE, legal coin handshake: latch the coin; credit += 5 or 10; go to DRIVE.
- IDLE, illegal coin handshake: request is consumed; err_illegal pulses the next cycle; stay in IDLE; credit unchanged.
- DRIVE: the selected coin line is high for exactly PULSE_CYCLES consecutive cycles, starting the cycle after the handshake. Then go to GAP.
- GAP: both coin lines low for GAP_CYCLES cycles. Then go to WAIT_VEND if credit >= PRICE, otherwise IDLE.
- WAIT_VEND: a cycle counter starts at 0.
  - vm_dispense = 1 is sampled: next cycle done_valid = 1; done_change = the sampled vm_change; err_change asserts if the sampled vm_change != (credit > PRICE). credit clears to 0 and the state returns to IDLE.
  - Counter reaches TIMEOUT-1 with no dispense: err_timeout pulses the next cycle; credit clears; state returns to IDLE.
  - Dispense on the final counter cycle takes priority over timeout.
- vm_dispense high in IDLE, DRIVE or GAP: err_spurious pulses the next cycle. State, credit and counters are unaffected. The error repeats for every high cycle.
- Credit width: before the final coin credit is at most 20, so after the final coin it is at most 30 (PRICE = 25 with a 10c coin). Five bits suffices, so there is no overflow logic.
- coin_5 and coin_10 are never high together.
- At most one of done_valid and err_timeout asserts in any cycle.

Test Plan:
- Coins 5, 10 back-to-back (req_valid held high): coin_5 high for cycles 1-4 after the first handshake; gap for 2 cycles; req_ready returns high; coin_10 high for 4 cycles; credit reads 5 then 15. Drive vm_dispense=1, vm_change=0 three cycles into WAIT_VEND → done_valid=1, done_change=0, err_change=0, credit=0.
- Coins 10, 10 with the core answering vm_dispense=1, vm_change=1 → done_change=1, err_change=0. Same stimulus but vm_change=0 → err_change=1.
- Coin 10 then 5, no dispense → err_timeout pulses exactly TIMEOUT cycles after WAIT_VEND entry; credit=0; busy=0.
- req_coin = 00, then 11 → each consumed in one cycle with err_illegal pulsed; coin lines stay low; credit stays 0.
- vm_dispense pulsed during DRIVE → err_spurious the next cycle; the pulse still lasts exactly 4 cycles.
- rst asserted on the 2nd cycle of a coin_10 pulse → coin_10=0 and credit=0 the next cycle; req_ready=1; a new 5c coin then behaves exactly as after power-up.
